calc_seq_alu: RTL and testbench

//   Sequential arithmetic unit for the calculator datapath. Consumes the two binary operands

---
 rtl/calc_seq_alu.sv | 143 ++++++++++++++
 tb/tb_calc_seq_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_alu.sv
// Sequential add/sub/mul/div unit feeding the binary-to-BCD stage.
// Add and sub take one compute cycle. Mul and div iterate one bit per clock, then spend one cycle writing the result.
module calc_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Start,
    input  logic [1:0]           i_Op,
    input  logic [WIDTH-1:0]     i_A,
    input  logic [WIDTH-1:0]     i_B,
    output logic                 o_Busy,
    output logic [2*WIDTH-1:0]   o_Result,
    output logic                 o_Neg,
    output logic                 o_Err,
    output logic                 o_DV
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_rem;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]     r_cnt;

    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_rem_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic                 w_last;

    assign w_sum     = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
    assign w_diff    = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);
    // Restoring step: remainder is always < divisor, so the difference fits WIDTH bits.
    assign w_rem_sh  = {r_rem, r_a[WIDTH-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_last    = (r_cnt == CNT_W'(WIDTH));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            o_Busy   <= 1'b0;
            o_Result <= '0;
            o_Neg    <= 1'b0;
            o_Err    <= 1'b0;
            o_DV     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_DV <= 1'b0;
                    if (i_Start) begin
                        r_op    <= i_Op;
                        r_a     <= i_A;
                        r_b     <= i_B;
                        r_rem   <= '0;
                        r_prod  <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, i_B};
                        r_cnt   <= '0;
                        o_Busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    case (r_op)
                        2'b00: begin
                            o_Result <= w_sum;
                            o_Neg    <= 1'b0;
                            o_Err    <= 1'b0;
                            o_DV     <= 1'b1;
                            r_state  <= S_DONE;
                        end
                        2'b01: begin
                            o_Result <= {{WIDTH{1'b0}}, w_diff};
                            o_Neg    <= (r_a < r_b);
                            o_Err    <= 1'b0;
                            o_DV     <= 1'b1;
                            r_state  <= S_DONE;
                        end
                        2'b10: begin
                            if (w_last) begin
                                o_Result <= r_prod;
                                o_Neg    <= 1'b0;
                                o_Err    <= 1'b0;
                                o_DV     <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                if (r_a[0]) r_prod <= r_prod + r_mcand;
                                r_mcand <= r_mcand << 1;
                                r_a     <= r_a >> 1;
                                r_cnt   <= r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (r_b == '0) begin
                                o_Result <= '0;
                                o_Neg    <= 1'b0;
                                o_Err    <= 1'b1;
                                o_DV     <= 1'b1;
                                r_state  <= S_DONE;
                            end else if (w_last) begin
                                o_Result <= {r_rem, r_a};
                                o_Neg    <= 1'b0;
                                o_Err    <= 1'b0;
                                o_DV     <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_rem <= w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                                r_a   <= {r_a[WIDTH-2:0], w_rem_ge};
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    endcase
                end
                S_DONE: begin
                    o_DV    <= 1'b0;
                    o_Busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_DV    <= 1'b0;
                    o_Busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Randomized bench for calc_seq_alu: an arithmetic reference model predicts busy/valid timing and results every cycle.
module tb_calc_seq_alu;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
    logic           dv;

    calc_seq_alu #(.WIDTH(W)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Op(op), .i_A(a), .i_B(b),
        .o_Busy(busy), .o_Result(res), .o_Neg(neg), .o_Err(err), .o_DV(dv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: accepted request, its acceptance edge and latency, and last delivered outputs.
    bit             m_active = 1'b0;
    int             m_ea = 0;
    int             m_L = 0;
    logic [2*W-1:0] p_res = '0;
    logic           p_neg = 1'b0;
    logic           p_err = 1'b0;
    logic [2*W-1:0] m_res = '0;
    logic           m_neg = 1'b0;
    logic           m_err = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [2*W-1:0] r, output logic n, output logic e,
                                  output int lat);
        int ix, iy;
        ix = int'(x);
        iy = int'(y);
        n = 1'b0;
        e = 1'b0;
        lat = 2;
        case (o)
            2'd0: r = (2*W)'(ix + iy);
            2'd1: begin
                r = (2*W)'((ix >= iy) ? ix - iy : iy - ix);
                n = (ix < iy);
            end
            2'd2: begin
                r = (2*W)'(ix * iy);
                lat = W + 2;
            end
            default: begin
                if (iy == 0) begin
                    r = '0;
                    e = 1'b1;
                end else begin
                    r = (2*W)'(((ix % iy) << W) + (ix / iy));
                    lat = W + 2;
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        bit eb, ed;
        eb = m_active && (cyc >= m_ea) && (cyc <= m_ea + m_L - 1);
        ed = m_active && (cyc == m_ea + m_L - 1);
        if (ed) begin
            m_res = p_res;
            m_neg = p_neg;
            m_err = p_err;
        end
        chk("busy", busy, eb);
        chk("dv", dv, ed);
        chk("result", res, m_res);
        chk("neg", neg, m_neg);
        chk("err", err, m_err);
    end

    task automatic tick(input bit s, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        #1;
        start = s;
        op = o;
        a = x;
        b = y;
        if (s && rst_n && (!m_active || cyc >= m_ea + m_L)) begin
            model(o, x, y, p_res, p_neg, p_err, m_L);
            m_ea = cyc + 1;
            m_active = 1'b1;
        end
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input longint eres, input bit eneg, input bit eerr, input int elat, input int poke);
        int n0, k;
        tick(1'b1, o, x, y);
        n0 = cyc;
        for (k = 1; k <= 40; k++) begin
            tick(k == poke, 2'($urandom), W'($urandom), W'($urandom));
            if (dv) break;
        end
        chk({name, "_lat"}, cyc - n0, elat);
        chk({name, "_res"}, res, eres);
        chk({name, "_neg"}, neg, eneg);
        chk({name, "_err"}, err, eerr);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return W'(1);
            2: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [2*W-1:0] r;
        logic n, e;
        int l;

        model(2'd2, 8'd255, 8'd255, r, n, e, l);
        chk("model_mul", r, 16'hFE01);
        chk("model_mul_lat", l, 10);
        model(2'd3, 8'd99, 8'd7, r, n, e, l);
        chk("model_div", r, 16'h010E);
        model(2'd1, 8'd12, 8'd47, r, n, e, l);
        chk("model_sub", {r, n}, {16'd35, 1'b1});

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dv", dv, 0);
        chk("rst_res", res, 0);
        rst_n = 1'b1;

        run("add",     2'd0, 8'd25,  8'd17,  42,       0, 0, 2,     0);
        run("add_cy",  2'd0, 8'd255, 8'd255, 510,      0, 0, 2,     0);
        run("sub_neg", 2'd1, 8'd12,  8'd47,  35,       1, 0, 2,     0);
        run("sub_eq",  2'd1, 8'd47,  8'd47,  0,        0, 0, 2,     0);
        run("mul99",   2'd2, 8'd99,  8'd99,  16'h2649, 0, 0, W + 2, 0);
        run("mul255",  2'd2, 8'd255, 8'd255, 16'hFE01, 0, 0, W + 2, 0);
        run("div",     2'd3, 8'd99,  8'd7,   16'h010E, 0, 0, W + 2, 0);
        run("div0",    2'd3, 8'd50,  8'd0,   0,        0, 1, 2,     0);
        run("mul_poke", 2'd2, 8'd13, 8'd11,  143,      0, 0, W + 2, 4);

        tick(1'b1, 2'd2, 8'd200, 8'd3);
        repeat (3) tick(1'b0, 2'd0, 8'd0, 8'd0);
        rst_n = 1'b0;
        m_active = 1'b0;
        m_res = '0;
        m_neg = 1'b0;
        m_err = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_dv", dv, 0);
        chk("abort_res", res, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run("add_after", 2'd0, 8'd25, 8'd17, 42, 0, 0, 2, 0);

        repeat (3000) tick(($urandom % 3) == 0, 2'($urandom), pick(), pick());
        repeat (W + 6) tick(1'b0, 2'd0, 8'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
